// File: rtl/rom_programmer_if.sv
// Host and chip-pin bundle for the 556PT5 fuse-ROM programmer.
// The master side is the host plus the chip; the slave side is the programmer.
interface rom_programmer_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 9
);
    logic                     start;
    logic [ADDRESS_WIDTH-1:0] address_in;
    logic [DATA_WIDTH-1:0]    data_in;
    logic                     ready;
    logic                     busy;
    logic                     done;
    logic [1:0]               err_code;
    logic [DATA_WIDTH-1:0]    read_back;
    logic [3:0]               operation;
    logic [ADDRESS_WIDTH-1:0] address_line;
    logic [DATA_WIDTH-1:0]    data_line_out;
    logic                     data_line_oe;
    logic [DATA_WIDTH-1:0]    data_line_in;

    modport master (
        output start, address_in, data_in, data_line_in,
        input  ready, busy, done, err_code, read_back,
               operation, address_line, data_line_out, data_line_oe
    );

    modport slave (
        input  start, address_in, data_in, data_line_in,
        output ready, busy, done, err_code, read_back,
               operation, address_line, data_line_out, data_line_oe
    );
endinterface

// File: rtl/rom_programmer.sv
// Programs one word of a 556PT5 fuse ROM: read, blow the lowest missing bit,
// re-read, repeat until the word matches, a bit proves unprogrammable or retries run out.
module rom_programmer #(
    parameter int         DATA_WIDTH    = 8,
    parameter int         ADDRESS_WIDTH = 9,
    parameter int         SETTLE_CYCLES = 16,
    parameter int         PULSE_CYCLES  = 1000,
    parameter int         MAX_RETRIES   = 8,
    parameter logic [3:0] READ_CODE     = 4'b0011,
    parameter logic [3:0] PROG_CODE     = 4'b1101
) (
    input logic              clk,
    input logic              reset_n,
    rom_programmer_if.slave  bus
);
    localparam int CNT_MAX = (SETTLE_CYCLES > PULSE_CYCLES) ? SETTLE_CYCLES : PULSE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 2);

    localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   PULSE_LAST  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE, SETUP, SAMPLE, SELECT, PULSE, RECOVER, FINISH
    } state_e;

    state_e                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [RETRY_W-1:0]       retry_q;
    logic [DATA_WIDTH-1:0]    target_q;
    logic [DATA_WIDTH-1:0]    prev_bit_q;
    logic [DATA_WIDTH-1:0]    read_back_q;
    logic [ADDRESS_WIDTH-1:0] address_line_q;
    logic [DATA_WIDTH-1:0]    data_line_out_q;
    logic                     data_line_oe_q;
    logic [3:0]               operation_q;
    logic [1:0]               err_code_q;
    logic                     done_q;
    logic                     ready_q;
    logic                     busy_q;

    logic [DATA_WIDTH-1:0] need_d;
    logic [DATA_WIDTH-1:0] sel_d;
    logic                  bad_d;
    logic [RETRY_W-1:0]    retry_d;

    // Lowest missing bit is isolated with x & -x; a repeat of the same bit is a retry.
    always_comb begin
        need_d  = target_q & ~read_back_q;
        bad_d   = |(read_back_q & ~target_q);
        sel_d   = need_d & (~need_d + 1'b1);
        retry_d = RETRY_W'(1);
        if (sel_d == prev_bit_q) begin
            retry_d = (retry_q == '1) ? retry_q : retry_q + 1'b1;
        end
    end

    // NOTE: chip-facing outputs are flops with async clear, so pulling reset_n low
    // drops the programming voltage and data drive without waiting for a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            retry_q         <= '0;
            target_q        <= '0;
            prev_bit_q      <= '0;
            read_back_q     <= '0;
            address_line_q  <= '0;
            data_line_out_q <= '0;
            data_line_oe_q  <= 1'b0;
            operation_q     <= 4'b0000;
            err_code_q      <= 2'b00;
            done_q          <= 1'b0;
            ready_q         <= 1'b1;
            busy_q          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads the
            // values registered at the start of this cycle.
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        address_line_q <= bus.address_in;
                        target_q       <= bus.data_in;
                        err_code_q     <= 2'b00;
                        retry_q        <= '0;
                        prev_bit_q     <= '0;
                        cnt_q          <= '0;
                        operation_q    <= READ_CODE;
                        ready_q        <= 1'b0;
                        busy_q         <= 1'b1;
                        state_q        <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q   <= '0;
                        state_q <= SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SAMPLE: begin
                    read_back_q <= bus.data_line_in;
                    state_q     <= SELECT;
                end
                SELECT: begin
                    if (bad_d) begin
                        err_code_q  <= 2'b01;
                        done_q      <= 1'b1;
                        operation_q <= 4'b0000;
                        state_q     <= FINISH;
                    end else if (need_d == '0) begin
                        err_code_q  <= 2'b00;
                        done_q      <= 1'b1;
                        operation_q <= 4'b0000;
                        state_q     <= FINISH;
                    end else begin
                        retry_q    <= retry_d;
                        prev_bit_q <= sel_d;
                        if (retry_d > RETRY_LIMIT) begin
                            err_code_q  <= 2'b10;
                            done_q      <= 1'b1;
                            operation_q <= 4'b0000;
                            state_q     <= FINISH;
                        end else begin
                            operation_q     <= PROG_CODE;
                            data_line_out_q <= sel_d;
                            data_line_oe_q  <= 1'b1;
                            cnt_q           <= '0;
                            state_q         <= PULSE;
                        end
                    end
                end
                PULSE: begin
                    if (cnt_q == PULSE_LAST) begin
                        operation_q     <= 4'b0000;
                        data_line_out_q <= '0;
                        data_line_oe_q  <= 1'b0;
                        cnt_q           <= '0;
                        state_q         <= RECOVER;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RECOVER: begin
                    if (cnt_q == SETTLE_LAST) begin
                        operation_q <= READ_CODE;
                        cnt_q       <= '0;
                        state_q     <= SETUP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FINISH: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready         = ready_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.err_code      = err_code_q;
    assign bus.read_back     = read_back_q;
    assign bus.operation     = operation_q;
    assign bus.address_line  = address_line_q;
    assign bus.data_line_out = data_line_out_q;
    assign bus.data_line_oe  = data_line_oe_q;
endmodule

// File: tb/tb_rom_programmer.sv
// Directed bench for rom_programmer with a fuse-chip model: blown bits latch after one
// pulse unless marked stuck; pin-level rules are watched on every falling clock edge.
module tb_rom_programmer;
    localparam int         DW     = 8;
    localparam int         AW     = 9;
    localparam int         SETTLE = 16;
    localparam int         PULSE  = 1000;
    localparam int         MAXR   = 8;
    localparam logic [3:0] RD     = 4'b0011;
    localparam logic [3:0] PG     = 4'b1101;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rom_programmer_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    rom_programmer #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .SETTLE_CYCLES(SETTLE),
        .PULSE_CYCLES(PULSE), .MAX_RETRIES(MAXR), .READ_CODE(RD), .PROG_CODE(PG)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    // Chip model: drives the word only while the read levels are applied.
    logic [DW-1:0] chip_word = '0;
    logic [DW-1:0] stuck     = '0;
    assign bus.data_line_in = (bus.operation == RD) ? chip_word : '1;

    int passed = 0;
    int total  = 0;

    int            done_cnt = 0;
    int            phases   = 0;
    int            viol     = 0;
    int            run_len  = 0;
    logic          prev_oe  = 1'b0;
    logic [DW-1:0] last_dout = '0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] pulse_log[$];

    typedef struct {
        string         name;
        logic [DW-1:0] chip;
        logic [DW-1:0] stuck;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    err;
        logic [DW-1:0] rb;
        int            pulses;
        logic [DW-1:0] first;
        logic [DW-1:0] last;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One cycle of time plus pin-level monitoring and the chip's fuse behaviour.
    task automatic tick();
        @(negedge clk);
        if (bus.done) done_cnt++;
        if (bus.data_line_oe) begin
            if (!prev_oe) begin
                phases++;
                pulse_log.push_back(bus.data_line_out);
            end
            run_len++;
            last_dout = bus.data_line_out;
            if (bus.operation != PG || !$onehot(bus.data_line_out)) viol++;
        end else begin
            if (prev_oe) begin
                if (run_len != PULSE) viol++;
                chip_word = chip_word | (last_dout & ~stuck);
                run_len = 0;
            end
            if (bus.data_line_out != '0) viol++;
        end
        if (bus.busy && bus.address_line != exp_addr) viol++;
        if (bus.ready == bus.busy) viol++;
        prev_oe = bus.data_line_oe;
    endtask

    task automatic accept(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.address_in = a;
        bus.data_in    = d;
        bus.start      = 1'b1;
        exp_addr       = a;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < 40000) begin
            tick();
            n++;
        end
        if (!bus.done) check("done_timeout", 32'(n), 32'hFFFF_FFFF);
    endtask

    initial begin
        int lat;
        int d0, p0, v0;
        logic [DW-1:0] first_b, last_b;

        vecs[0] = '{"blank_0x81",     8'h00, 8'h00, 9'h1A5, 8'h81, 2'b00, 8'h81, 2,  8'h01, 8'h80};
        vecs[1] = '{"already_0x81",   8'h81, 8'h00, 9'h1A5, 8'h81, 2'b00, 8'h81, 0,  8'h00, 8'h00};
        vecs[2] = '{"unprogrammable", 8'h02, 8'h00, 9'h003, 8'h01, 2'b01, 8'h02, 0,  8'h00, 8'h00};
        vecs[3] = '{"stuck_bit3",     8'h00, 8'h08, 9'h100, 8'h08, 2'b10, 8'h00, 8,  8'h08, 8'h08};
        vecs[4] = '{"blank_zero",     8'h00, 8'h00, 9'h0FF, 8'h00, 2'b00, 8'h00, 0,  8'h00, 8'h00};
        vecs[5] = '{"partial_0x35",   8'h10, 8'h00, 9'h07E, 8'h35, 2'b00, 8'h35, 3,  8'h01, 8'h20};
        vecs[6] = '{"stuck_bit7",     8'h00, 8'h80, 9'h1FF, 8'hFF, 2'b10, 8'h7F, 15, 8'h01, 8'h80};

        bus.start      = 1'b0;
        bus.address_in = '0;
        bus.data_in    = '0;

        @(negedge clk);
        @(negedge clk);
        check("rst_ready", bus.ready, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_oe", bus.data_line_oe, 1'b0);
        check("rst_op", bus.operation, 4'b0000);
        check("rst_dout", bus.data_line_out, 8'h00);
        check("rst_addr", bus.address_line, 9'h000);
        check("rst_rb", bus.read_back, 8'h00);
        check("rst_err", bus.err_code, 2'b00);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            chip_word = vecs[i].chip;
            stuck     = vecs[i].stuck;
            pulse_log.delete();
            d0 = done_cnt; p0 = phases; v0 = viol;
            accept(vecs[i].addr, vecs[i].data);
            wait_done(lat);
            check({vecs[i].name, "_err"}, bus.err_code, vecs[i].err);
            check({vecs[i].name, "_rb"}, bus.read_back, vecs[i].rb);
            check({vecs[i].name, "_latency"}, 32'(lat),
                  32'(SETTLE + 2 + vecs[i].pulses * (PULSE + 2 * SETTLE + 2)));
            tick();
            check({vecs[i].name, "_ready_after"}, bus.ready, 1'b1);
            check({vecs[i].name, "_pulses"}, 32'(phases - p0), 32'(vecs[i].pulses));
            check({vecs[i].name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
            check({vecs[i].name, "_pin_rules"}, 32'(viol - v0), 32'd0);
            first_b = (pulse_log.size() > 0) ? pulse_log[0] : '0;
            last_b  = (pulse_log.size() > 0) ? pulse_log[pulse_log.size() - 1] : '0;
            check({vecs[i].name, "_first_bit"}, first_b, vecs[i].first);
            check({vecs[i].name, "_last_bit"}, last_b, vecs[i].last);
        end

        // Zero-pulse completion bound from acceptance.
        chip_word = 8'h81; stuck = '0;
        accept(9'h1A5, 8'h81);
        wait_done(lat);
        check("noop_within_bound", 32'(lat <= SETTLE + 3), 32'd1);
        tick();

        // err_code/read_back hold while idle, err_code clears on the next acceptance.
        chip_word = 8'h02; stuck = '0;
        accept(9'h011, 8'h01);
        wait_done(lat);
        for (int k = 0; k < 5; k++) tick();
        check("hold_err", bus.err_code, 2'b01);
        check("hold_rb", bus.read_back, 8'h02);
        chip_word = 8'h00;
        accept(9'h012, 8'h00);
        check("err_clear_on_accept", bus.err_code, 2'b00);
        check("busy_after_accept", bus.busy, 1'b1);
        wait_done(lat);
        tick();

        // start pulsed mid-operation with different address/data must be ignored.
        chip_word = 8'h00; stuck = '0;
        d0 = done_cnt; p0 = phases; v0 = viol;
        accept(9'h055, 8'h02);
        for (int k = 0; k < 5; k++) tick();
        bus.address_in = 9'h1FF;
        bus.data_in    = 8'hFF;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(lat);
        for (int k = 0; k < 4; k++) tick();
        check("busy_start_rb", bus.read_back, 8'h02);
        check("busy_start_err", bus.err_code, 2'b00);
        check("busy_start_pulses", 32'(phases - p0), 32'd1);
        check("busy_start_done_count", 32'(done_cnt - d0), 32'd1);
        check("busy_start_addr_stable", 32'(viol - v0), 32'd0);
        check("busy_start_idle", bus.ready, 1'b1);

        // Reset between clock edges in the middle of a programming pulse.
        chip_word = 8'h00; stuck = '0;
        accept(9'h0F0, 8'h04);
        lat = 0;
        while (!bus.data_line_oe && lat < 200) begin
            tick();
            lat++;
        end
        check("reach_pulse", bus.data_line_oe, 1'b1);
        for (int k = 0; k < 3; k++) tick();
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_op", bus.operation, 4'b0000);
        check("async_rst_oe", bus.data_line_oe, 1'b0);
        check("async_rst_dout", bus.data_line_out, 8'h00);
        check("async_rst_addr", bus.address_line, 9'h000);
        check("async_rst_ready", bus.ready, 1'b1);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("ready_after_release", bus.ready, 1'b1);
        check("busy_after_release", bus.busy, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
